// File: rtl/rca_16b_pkg.sv
// Shared constants for the 16-bit ripple-carry adder.
// The optional overflow outputs are controlled by the RCA_16B_OVF_EN macro in rca_16b.
package rca_16b_pkg;

  // Default operand width. Only 16 is supported.
  localparam int unsigned RcaWidth = 16;

  // The registered result holds the carry out plus all sum bits.
  localparam int unsigned RcaSumWidth = RcaWidth + 1;

  // Value of sum_q while the block is in reset.
  localparam logic [RcaSumWidth-1:0] RcaSumRst = '0;

endpackage : rca_16b_pkg

// File: rtl/rca_16b_fa.sv
// One-bit full adder. This is one stage of the rca_16b ripple chain.
module rca_16b_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum bit and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : rca_16b_fa

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder.
// The sum and carry out are combinational. A copy of {COUT, SOUT} is registered in sum_q.
// Define RCA_16B_OVF_EN to add the signed-overflow outputs ovf and ovf_q.
module rca_16b
  import rca_16b_pkg::*;
#(
  parameter int unsigned WIDTH = RcaWidth
) (
  input  logic           clk,
  input  logic           rst,
  output logic           COUT,
  input  logic           CIN,
  output logic [WIDTH-1:0] SOUT,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   sum_q
`ifdef RCA_16B_OVF_EN
  ,
  output logic           ovf,
  output logic           ovf_q
`endif
);

  // carry[i] is the carry into stage i. carry[WIDTH] is the carry out of the top stage.
  logic [WIDTH:0] carry;

  assign carry[0] = CIN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    rca_16b_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (SOUT[i]),
      .co (carry[i+1])
    );
  end

  assign COUT = carry[WIDTH];

  // Capture the full result on every edge. Reset clears it without waiting for the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= RcaSumRst;
    end else begin
      sum_q <= {COUT, SOUT};
    end
  end

`ifdef RCA_16B_OVF_EN
  // Signed overflow occurs when the carry into the sign bit differs from the carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  // Register the overflow flag in the same cycle as sum_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf;
    end
  end
`endif

endmodule : rca_16b

// File: tb/tb_rca_16b.sv
// Self-checking bench for rca_16b.
// A queue-based scoreboard compares against an arithmetic reference model.
// Build with RCA_16B_OVF_EN to also check ovf and ovf_q.
module tb_rca_16b;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] sum;
    logic        ovf;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        COUT;
  logic        CIN;
  logic [15:0] SOUT;
  logic [15:0] A;
  logic [15:0] B;
  logic [16:0] sum_q;
`ifdef RCA_16B_OVF_EN
  logic        ovf;
  logic        ovf_q;
`endif

  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  rca_16b dut (
    .clk   (clk),
    .rst   (rst),
    .COUT  (COUT),
    .CIN   (CIN),
    .SOUT  (SOUT),
    .A     (A),
    .B     (B),
    .sum_q (sum_q)
`ifdef RCA_16B_OVF_EN
    ,
    .ovf   (ovf),
    .ovf_q (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer addition, plus a signed range test for overflow.
  function automatic entry_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    entry_t      e;
    int unsigned u;
    int          s;
    u = int'(a) + int'(b) + int'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.a   = a;
    e.b   = b;
    e.cin = cin;
    e.sum = u[16:0];
    e.ovf = (s > 32767) || (s < -32768);
    return e;
  endfunction

  // Drive one vector after a falling edge and queue its expected result.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    A   = a;
    B   = b;
    CIN = cin;
    exp_q.push_back(model(a, b, cin));
  endtask

  // Monitor: pop one entry per rising edge.
  // Check the combinational outputs at the edge and sum_q just after it.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("comb_sum", {COUT, SOUT}, e.sum);
`ifdef RCA_16B_OVF_EN
        check("comb_ovf", {16'h0, ovf}, {16'h0, e.ovf});
`endif
        #1;
        check("sum_q", sum_q, e.sum);
`ifdef RCA_16B_OVF_EN
        check("ovf_q", {16'h0, ovf_q}, {16'h0, e.ovf});
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b0;
    A   = 16'h1234;
    B   = 16'h4321;
    CIN = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset_async", sum_q, 17'h0);
`ifdef RCA_16B_OVF_EN
    check("reset_ovf_q", {16'h0, ovf_q}, 17'h0);
`endif
    // While reset is high, clock edges must not capture a result.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", sum_q, 17'h0);
    check("reset_comb", {COUT, SOUT}, 17'h05556);
    @(negedge clk);
    rst = 1'b0;

    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'hFFFF, 16'h0001, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);

    // Pulse reset between edges while sum_q holds 0x1FFFF.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sum_q", sum_q, 17'h0);
    check("mid_rst_comb", {COUT, SOUT}, 17'h1FFFF);
    #1 rst = 1'b0;
    // Keep the same inputs. The first edge after reset is released should recapture them.
    drive(16'hFFFF, 16'hFFFF, 1'b1);

    drive(16'h7FFF, 16'h0001, 1'b0);
    drive(16'h8000, 16'h8000, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Wait a bounded number of cycles for the scoreboard to drain.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("drain", 17'(exp_q.size()), 17'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_16b
